// File: rtl/bash_f_ctrl.sv
// bash-f permutation sequencer: holds the 1536-bit sponge state, steps it
// through ROUNDS rounds (UNROLL per clock) and hands the result back with
// valid/ready handshakes on both sides.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for a state to load; in_ready_o high
// RUN     | applying UNROLL rounds per clock until ROUNDS are done
// DONE    | result on out_state_o, held until out_ready_i
module bash_f_ctrl #(
    parameter int UNROLL = 1,
    parameter int ROUNDS = 24
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [1535:0] in_state_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [1535:0] out_state_o,
    output logic          busy_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [63:0] C1     = 64'h3BF5080AC8BA94B1;
    localparam logic [63:0] C_POLY = 64'hDC2BE1997FE0D8AE;

    localparam int CW = $clog2(ROUNDS + UNROLL + 1);
    localparam logic [CW-1:0] UNROLL_W = CW'(UNROLL);
    localparam logic [CW-1:0] ROUNDS_W = CW'(ROUNDS);

    logic [1:0]    fsm_q, fsm_d;
    logic [1535:0] state_q, state_d;
    logic [63:0]   const_q, const_d;
    logic [CW-1:0] ctr_q, ctr_d;
    logic [1535:0] rnd_state;
    logic [63:0]   rnd_const;

    // Stored words are little-endian byte images; arithmetic works on the
    // numeric value, so every word is swapped in and out of the round.
    function automatic logic [63:0] bswap64(input logic [63:0] x);
        logic [63:0] y;
        for (int b = 0; b < 8; b++) y[8*b +: 8] = x[8*(7-b) +: 8];
        return y;
    endfunction

    function automatic logic [63:0] rotl64(input logic [63:0] x, input int n);
        return (x << n) | (x >> (64 - n));
    endfunction

    function automatic logic [63:0] c_next(input logic [63:0] c);
        return c[0] ? ((c >> 1) ^ C_POLY) : (c >> 1);
    endfunction

    // Source word for each destination word of the permutation P.
    function automatic int perm_src(input int i);
        case (i)
            0: return 15;  1: return 10;  2: return 9;   3: return 12;
            4: return 11;  5: return 14;  6: return 13;  7: return 8;
            8: return 17;  9: return 16;  10: return 19; 11: return 18;
            12: return 21; 13: return 20; 14: return 23; 15: return 22;
            16: return 6;  17: return 3;  18: return 0;  19: return 7;
            20: return 2;  21: return 5;  22: return 4;  23: return 1;
            default: return 0;
        endcase
    endfunction

    // Column S-box with per-column rotation/shift amounts; returns {w2,w1,w0}.
    function automatic logic [191:0] bash_col(input int j, input logic [63:0] a0,
                                              input logic [63:0] a1, input logic [63:0] a2);
        int m1, n1, m2, n2;
        logic [63:0] x0, x1, x2, y0, y1;
        case (j)
            1:       begin m1 = 56; n1 = 51; m2 = 34; n2 = 7;  end
            2:       begin m1 = 8;  n1 = 37; m2 = 46; n2 = 49; end
            3:       begin m1 = 56; n1 = 3;  m2 = 2;  n2 = 23; end
            4:       begin m1 = 8;  n1 = 21; m2 = 14; n2 = 33; end
            5:       begin m1 = 56; n1 = 19; m2 = 34; n2 = 39; end
            6:       begin m1 = 8;  n1 = 5;  m2 = 46; n2 = 17; end
            7:       begin m1 = 56; n1 = 35; m2 = 2;  n2 = 55; end
            default: begin m1 = 8;  n1 = 53; m2 = 14; n2 = 1;  end
        endcase
        y0 = rotl64(a0, m1);
        x0 = a0 ^ a1 ^ a2;
        y1 = a1 ^ rotl64(x0, n1);
        x1 = y0 ^ y1;
        x2 = a2 ^ rotl64(a2, m2) ^ (y1 << n2);
        return {x2 ^ (x0 & x1), x1 ^ (x0 | x2), x0 ^ (~x2 | x1)};
    endfunction

    function automatic logic [1535:0] bash_round(input logic [1535:0] s_in, input logic [63:0] c);
        logic [63:0]   w [24];
        logic [63:0]   v [24];
        logic [191:0]  col;
        logic [1535:0] s_out;
        for (int i = 0; i < 24; i++) w[i] = bswap64(s_in[64*i +: 64]);
        for (int j = 0; j < 8; j++) begin
            col      = bash_col(j, w[j], w[8+j], w[16+j]);
            v[j]     = col[63:0];
            v[8+j]   = col[127:64];
            v[16+j]  = col[191:128];
        end
        for (int i = 0; i < 24; i++) s_out[64*i +: 64] = bswap64(v[perm_src(i)]);
        s_out[1535:1472] = s_out[1535:1472] ^ bswap64(c);
        return s_out;
    endfunction

    // Chain UNROLL rounds (and their constants) within one clock.
    always_comb begin
        rnd_state = state_q;
        rnd_const = const_q;
        for (int k = 0; k < UNROLL; k++) begin
            rnd_state = bash_round(rnd_state, rnd_const);
            rnd_const = c_next(rnd_const);
        end
    end

    // Sequencer next-state: load in IDLE, step in RUN, hold result in DONE.
    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        const_d = const_q;
        ctr_d   = ctr_q;
        case (fsm_q)
            ST_IDLE: begin
                if (in_valid_i) begin
                    state_d = in_state_i;
                    const_d = C1;
                    ctr_d   = '0;
                    fsm_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                state_d = rnd_state;
                const_d = rnd_const;
                ctr_d   = ctr_q + UNROLL_W;
                if (ctr_q + UNROLL_W == ROUNDS_W) fsm_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready_i) fsm_d = ST_IDLE;
            end
            default: fsm_d = ST_IDLE;
        endcase
    end

    // State, counter and constant registers; reset discards any partial run.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fsm_q   <= ST_IDLE;
            state_q <= '0;
            const_q <= C1;
            ctr_q   <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            const_q <= const_d;
            ctr_q   <= ctr_d;
        end
    end

    assign in_ready_o  = (fsm_q == ST_IDLE);
    assign busy_o      = (fsm_q == ST_RUN);
    assign out_valid_o = (fsm_q == ST_DONE);
    assign out_state_o = state_q;

endmodule

// File: tb/tb_bash_f_ctrl.sv
// Random-stimulus bench for bash_f_ctrl against a word-level model of bash-f.
module tb_bash_f_ctrl;
    localparam int W = 1536;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         in_valid, out_ready, in_ready, out_valid, busy;
    logic [W-1:0] in_state, out_state;

    logic         aux_valid;
    logic [W-1:0] aux_state;
    logic         r1_rdy, r1_vld, r1_busy, r2a_rdy, r2a_vld, r2a_busy;
    logic         r2b_rdy, r2b_vld, r2b_busy, u4_rdy, u4_vld, u4_busy;
    logic [W-1:0] r1_out, r2a_out, r2b_out, u4_out;

    bash_f_ctrl dut (.clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_state_i(in_state), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_state_o(out_state), .busy_o(busy));
    bash_f_ctrl #(.UNROLL(1), .ROUNDS(1)) dut_r1 (.clk_i(clk), .rst_i(rst), .in_valid_i(aux_valid),
        .in_ready_o(r1_rdy), .in_state_i(aux_state), .out_valid_o(r1_vld), .out_ready_i(1'b1),
        .out_state_o(r1_out), .busy_o(r1_busy));
    bash_f_ctrl #(.UNROLL(1), .ROUNDS(2)) dut_r2a (.clk_i(clk), .rst_i(rst), .in_valid_i(aux_valid),
        .in_ready_o(r2a_rdy), .in_state_i(aux_state), .out_valid_o(r2a_vld), .out_ready_i(1'b1),
        .out_state_o(r2a_out), .busy_o(r2a_busy));
    bash_f_ctrl #(.UNROLL(2), .ROUNDS(2)) dut_r2b (.clk_i(clk), .rst_i(rst), .in_valid_i(aux_valid),
        .in_ready_o(r2b_rdy), .in_state_i(aux_state), .out_valid_o(r2b_vld), .out_ready_i(1'b1),
        .out_state_o(r2b_out), .busy_o(r2b_busy));
    bash_f_ctrl #(.UNROLL(4), .ROUNDS(24)) dut_u4 (.clk_i(clk), .rst_i(rst), .in_valid_i(aux_valid),
        .in_ready_o(u4_rdy), .in_state_i(aux_state), .out_valid_o(u4_vld), .out_ready_i(1'b1),
        .out_state_o(u4_out), .busy_o(u4_busy));

    int n_chk = 0;
    int n_err = 0;

    int M1 [8]  = '{8, 56, 8, 56, 8, 56, 8, 56};
    int N1 [8]  = '{53, 51, 37, 3, 21, 19, 5, 35};
    int M2 [8]  = '{14, 34, 46, 2, 14, 34, 46, 2};
    int N2 [8]  = '{1, 7, 49, 23, 33, 39, 17, 55};
    int PT [24] = '{15, 10, 9, 12, 11, 14, 13, 8, 17, 16, 19, 18, 21, 20, 23, 22,
                    6, 3, 0, 7, 2, 5, 4, 1};

    task automatic check(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
        int w;
        n_chk++;
        if (act !== exp) begin
            n_err++;
            w = 0;
            for (int i = 23; i >= 0; i--) if (act[64*i +: 64] !== exp[64*i +: 64]) w = i;
            $display("FAIL %s: got word%0d=%h, want %h", tag, w, act[64*w +: 64], exp[64*w +: 64]);
        end
    endtask

    function automatic logic [63:0] bsw(input logic [63:0] x);
        logic [63:0] y;
        for (int b = 0; b < 8; b++) y[8*b +: 8] = x[8*(7-b) +: 8];
        return y;
    endfunction

    function automatic logic [63:0] rl(input logic [63:0] x, input int n);
        return (x << n) | (x >> (64 - n));
    endfunction

    function automatic logic [W-1:0] rand_state();
        logic [W-1:0] r;
        for (int i = 0; i < 48; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // Reference: bash-f on numeric words, step list of bash-s taken literally.
    function automatic logic [W-1:0] model(input logic [W-1:0] st, input int rounds);
        logic [63:0] s [24];
        logic [63:0] t [24];
        logic [63:0] c, w0, w1, w2, t0, t1, t2;
        logic [W-1:0] r;
        c = 64'h3BF5080AC8BA94B1;
        for (int i = 0; i < 24; i++) s[i] = bsw(st[64*i +: 64]);
        for (int rr = 0; rr < rounds; rr++) begin
            for (int j = 0; j < 8; j++) begin
                w0 = s[j]; w1 = s[8+j]; w2 = s[16+j];
                t0 = rl(w0, M1[j]);
                w0 = w0 ^ w1 ^ w2;
                t1 = w1 ^ rl(w0, N1[j]);
                w1 = t0 ^ t1;
                w2 = w2 ^ rl(w2, M2[j]) ^ (t1 << N2[j]);
                t0 = ~w2;
                t1 = w0 | w2;
                t2 = w0 & w1;
                t0 = t0 | w1;
                w1 = w1 ^ t1;
                w2 = w2 ^ t2;
                w0 = w0 ^ t0;
                s[j] = w0; s[8+j] = w1; s[16+j] = w2;
            end
            for (int i = 0; i < 24; i++) t[i] = s[PT[i]];
            for (int i = 0; i < 24; i++) s[i] = t[i];
            s[23] = s[23] ^ c;
            if (c[0]) c = (c >> 1) ^ 64'hDC2BE1997FE0D8AE;
            else      c = c >> 1;
        end
        for (int i = 0; i < 24; i++) r[64*i +: 64] = bsw(s[i]);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int t = 0;
        while (!in_ready && t < 100) begin tick(); t++; end
        check("rdy_wait", W'(in_ready), W'(1));
    endtask

    // One load/unload on the default instance; optional DONE backpressure and
    // illegal in_valid pokes during RUN/DONE.
    task automatic run_one(input logic [W-1:0] st, input int hold, input bit poke);
        logic [W-1:0] exp, got;
        int n;
        exp = model(st, 24);
        wait_ready();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_state = st;
        tick();
        in_valid = 1'b0;
        in_state = rand_state();
        n = 0;
        while (!out_valid && n < 60) begin
            check("run_busy", W'(busy), W'(1));
            check("run_rdy", W'(in_ready), W'(0));
            in_valid = poke && (n % 5 == 3);
            tick();
            in_valid = 1'b0;
            n++;
        end
        check("done_vld", W'(out_valid), W'(1));
        check("latency", W'(n), W'(24));
        check("done_busy", W'(busy), W'(0));
        got = out_state;
        check("result", got, exp);
        for (int h = 0; h < hold; h++) begin
            in_valid = poke;
            tick();
            check("hold_vld", W'(out_valid), W'(1));
            check("hold_stable", out_state, got);
            check("hold_rdy", W'(in_ready), W'(0));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("unload_vld", W'(out_valid), W'(0));
        check("unload_rdy", W'(in_ready), W'(1));
        check("unload_busy", W'(busy), W'(0));
    endtask

    // One load into the four reduced/unrolled instances.
    task automatic aux_run(input logic [W-1:0] st, input bit zero_chk, input logic [W-1:0] zero_exp);
        logic [W-1:0] e1, e2, e24;
        bit g1, g2a, g2b, g4;
        e1 = zero_chk ? zero_exp : model(st, 1);
        e2 = model(st, 2);
        e24 = model(st, 24);
        g1 = 0; g2a = 0; g2b = 0; g4 = 0;
        aux_valid = 1'b1;
        aux_state = st;
        tick();
        aux_valid = 1'b0;
        aux_state = rand_state();
        for (int n = 0; n < 40; n++) begin
            if (r1_vld && !g1) begin
                g1 = 1; check("r1_lat", W'(n), W'(1)); check("r1_out", r1_out, e1);
            end
            if (r2a_vld && !g2a) begin
                g2a = 1; check("r2u1_lat", W'(n), W'(2)); check("r2u1_out", r2a_out, e2);
            end
            if (r2b_vld && !g2b) begin
                g2b = 1; check("r2u2_lat", W'(n), W'(1)); check("r2u2_out", r2b_out, e2);
            end
            if (u4_vld && !g4) begin
                g4 = 1; check("u4_lat", W'(n), W'(6)); check("u4_out", u4_out, e24);
            end
            tick();
        end
        check("aux_all_done", W'({g1, g2a, g2b, g4}), W'(4'hF));
    endtask

    initial begin
        logic [W-1:0] zero_exp, st0, st1, e0, e1;
        int cyc, nacc, nres, seen;
        int acc_cyc [2];

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_state = '0;
        aux_valid = 1'b0; aux_state = '0;
        #23;
        check("rst_rdy", W'(in_ready), W'(1));
        check("rst_vld", W'(out_valid), W'(0));
        check("rst_busy", W'(busy), W'(0));
        check("rst_state", out_state, '0);
        tick();
        rst = 1'b0;
        tick();

        zero_exp = '0;
        for (int i = 16; i < 23; i++) zero_exp[64*i +: 64] = '1;
        zero_exp[1535:1472] = 64'h4E6B4537F5F70AC4;
        aux_run('0, 1'b1, zero_exp);
        for (int k = 0; k < 8; k++) aux_run(rand_state(), 1'b0, '0);

        run_one(rand_state(), 10, 1'b1);
        for (int k = 0; k < 200; k++)
            run_one(rand_state(), int'($urandom_range(0, 3)), 1'(($urandom_range(0, 1))));

        // Back-to-back: in_valid held high, consumer always ready.
        wait_ready();
        st0 = rand_state(); st1 = rand_state();
        e0 = model(st0, 24); e1 = model(st1, 24);
        cyc = 0; nacc = 0; nres = 0;
        acc_cyc[0] = 0; acc_cyc[1] = 0;
        in_valid = 1'b1; out_ready = 1'b1; in_state = st0;
        while (nres < 2 && cyc < 120) begin
            if (in_ready && in_valid && nacc < 2) begin acc_cyc[nacc] = cyc; nacc++; end
            if (out_valid) begin
                check("b2b_result", out_state, (nres == 0) ? e0 : e1);
                nres++;
            end
            tick();
            cyc++;
            if (nacc == 1) in_state = st1;
            if (nacc == 2) in_valid = 1'b0;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        check("b2b_count", W'(nres), W'(2));
        check("b2b_interval", W'(acc_cyc[1] - acc_cyc[0]), W'(26));
        tick();

        // Asynchronous reset in the middle of RUN cycle 10.
        wait_ready();
        in_valid = 1'b1; in_state = rand_state();
        tick();
        in_valid = 1'b0;
        repeat (9) tick();
        check("pre_rst_busy", W'(busy), W'(1));
        #2;
        rst = 1'b1;
        #1;
        check("arst_rdy", W'(in_ready), W'(1));
        check("arst_vld", W'(out_valid), W'(0));
        check("arst_busy", W'(busy), W'(0));
        check("arst_state", out_state, '0);
        tick();
        rst = 1'b0;
        seen = 0;
        for (int n = 0; n < 30; n++) begin
            if (out_valid) seen = 1;
            tick();
        end
        check("arst_no_vld", W'(seen), W'(0));
        run_one(rand_state(), 2, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/bash_f_ctrl.md
Name: bash_f_ctrl

Overview:
- Sequencer for the bash-f sponge permutation: 1536-bit state, 24 words of 64 bits, 24 rounds.
- Each round:
  - applies the column S-box (bash_s_param) to the 8 columns (S[j], S[8+j], S[16+j]), j = 0..7;
  - applies word permutation P;
  - XORs round constant C_r into S[23].
- Holds the state register, round counter and constant LFSR, with valid/ready handshakes on load and unload.
- Sits between the sponge/absorb logic and the S-box datapath.

Parameters:
- UNROLL, 1, rounds per clock; legal values 1, 2, 3, 4 (must divide ROUNDS).
- ROUNDS, 24, rounds per permutation; non-24 values are for verification only.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- in_valid_i  in  1  load request.
- in_ready_o  out  1  block can accept a state.
- in_state_i  in  1536  input state; word i at bits [64i+63:64i], each word stored byte-reversed (little-endian bytes), as the S-box block expects.
- out_valid_o  out  1  permuted state available.
- out_ready_i  in  1  consumer accepts the result.
- out_state_o  out  1536  result, same layout as in_state_i.
- busy_o  out  1  high in RUN.

Behaviour:
- Reset values:
  - state = IDLE; in_ready_o = 1; out_valid_o = 0; busy_o = 0.
  - State register = 0; round counter = 0; constant register = C1.
- FSM IDLE -> RUN -> DONE -> IDLE.
  - IDLE:
    - in_ready_o = 1.
    - On in_valid_i & in_ready_o: register in_state_i, counter = 0, const = C1, go to RUN.
  - RUN:
    - in_ready_o = 0; busy_o = 1.
    - Each cycle, apply UNROLL rounds combinationally; counter += UNROLL.
    - When the counter reaches ROUNDS, go to DONE.
    - RUN lasts exactly ROUNDS/UNROLL cycles (24 at default).
  - DONE:
    - out_valid_o = 1; out_state_o is the registered state, held stable while out_valid_o & ~out_ready_i.
    - On out_ready_i: go to IDLE with in_ready_o = 1 in the following cycle. No same-cycle bypass from unload to load.
- Latency: load accepted at edge N -> out_valid_o high after edge N + ROUNDS/UNROLL.
- Column j S-box parameters (m1, n1, m2, n2):
  - j0 (8, 53, 14, 1); j1 (56, 51, 34, 7); j2 (8, 37, 46, 49); j3 (56, 3, 2, 23).
  - j4 (8, 21, 14, 33); j5 (56, 19, 34, 39); j6 (8, 5, 46, 17); j7 (56, 35, 2, 55).
- P, new word index <- old word index:
  - 0..7 <- 15, 10, 9, 12, 11, 14, 13, 8.
  - 8..15 <- 17, 16, 19, 18, 21, 20, 23, 22.
  - 16..23 <- 6, 3, 0, 7, 2, 5, 4, 1.
- Constants:
  - C1 = 0x3BF5080AC8BA94B1.
  - C_{r+1} = C_r>>1 when C_r is even, else (C_r>>1) ^ 0xDC2BE1997FE0D8AE.
  - C_r is numeric; it is byte-reversed before the XOR into stored S[23].
  - With UNROLL > 1, the chained constants are computed within the cycle.
- Inputs are ignored outside their states:
  - in_valid_i while in RUN or DONE: not accepted; in_ready_o = 0.
  - out_ready_i outside DONE: ignored.
- Reset mid-RUN or mid-DONE: immediate return to the reset values; the partial state is discarded and no out_valid_o pulse occurs.

Test Plan:
- ROUNDS=1, UNROLL=1, all-zero input:
  - out_valid_o after 1 RUN cycle.
  - Words 0..15 = 0; words 16..22 = 0xFFFFFFFFFFFFFFFF.
  - Word 23 bits = 0x4E6B4537F5F70AC4 (~C1, byte-reversed).
- ROUNDS=2, UNROLL=1 vs UNROLL=2, same random input:
  - Identical outputs.
  - Verifies C2 = 0xC1D1659C1BBD92F6 via the reference model.
- Default parameters, 200 random states vs the C model:
  - Bit-exact output.
  - Exactly 24 cycles from accept to out_valid_o (6 cycles with UNROLL=4).
- Backpressure:
  - Hold out_ready_i = 0 for 10 cycles in DONE: out_valid_o stays 1, out_state_o stable, in_ready_o = 0.
  - in_valid_i pulses during RUN and DONE are not accepted.
- Back-to-back operation: in_valid_i held high with out_ready_i = 1 -> loads accepted every 26 cycles (24 RUN + DONE + IDLE); both results correct.
- Assert rst_i asynchronously at RUN cycle 10:
  - Outputs go to reset values immediately, with no out_valid_o.
  - The next load completes correctly.
